// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe
// ----------------------------------------------------------------------------
// Two-stage immediate generator with valid/ready flow control.
//   Stage 1: decode EXTOp, extract and extend the immediate from instr, and
//            register it together with pc and the branch/jump class.
//   Stage 2: register out_imm and out_target (pc + imm for B/J classes only,
//            wrapping modulo 2^XLEN), plus out_err when enabled.
//
// Parameters:
//   XLEN      datapath width, 32 or 64
//   ADDR_REL  1: PC-relative target adder present, 0: out_target tied to 0
//
// Optional feature macro: IMMGEN_ILLEGAL_DETECT_EN
//   defined   : unknown EXTOp codes produce out_imm=0 with out_err=1
//   undefined : out_err is constant 0 and no detection logic exists
//
// Ports:
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   in_valid    in   instruction/pc pair presented
//   in_ready    out  stage 1 accepts this cycle
//   instr       in   raw 32-bit instruction word
//   EXTOp       in   6-bit extension select
//   pc          in   instruction address (XLEN)
//   flush       in   discard all in-flight entries
//   out_valid   out  result available
//   out_ready   in   consumer accepts result
//   out_imm     out  extended immediate (XLEN)
//   out_target  out  pc + out_imm for B/J, else 0 (XLEN)
//   out_err     out  illegal EXTOp flag
// ============================================================================
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int ADDR_REL = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [5:0]      EXTOp,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [XLEN-1:0] out_target,
   output logic            out_err
);

   localparam logic [5:0] OP_S     = 6'b000001;
   localparam logic [5:0] OP_I     = 6'b000010;
   localparam logic [5:0] OP_SHAMT = 6'b000011;
   localparam logic [5:0] OP_B     = 6'b000100;
   localparam logic [5:0] OP_U     = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000110;

   // Stage 1 state
   logic            r_s1_valid;
   logic [XLEN-1:0] r_s1_imm;
   logic [XLEN-1:0] r_s1_pc;
   logic            r_s1_br;

   // Stage 2 state
   logic            r_s2_valid;
   logic [XLEN-1:0] r_out_imm;
   logic [XLEN-1:0] r_out_target;

   logic            w_s2_adv;
   logic            w_s1_adv;
   logic            w_accept;
   logic            w_s2_load;
   logic [XLEN-1:0] w_imm;
   logic            w_is_br;
   logic [XLEN-1:0] w_target;
   logic            w_unused_opc;

   // Opcode field is never needed; the decode is driven by EXTOp alone.
   assign w_unused_opc = ^instr[6:0];

   // ---------------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------------
   assign w_s2_adv  = ~r_s2_valid | out_ready;
   assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
   // rstn term keeps in_ready low for the whole reset window.
   assign in_ready  = w_s1_adv & ~flush & rstn;
   assign w_accept  = in_valid & in_ready;
   assign w_s2_load = w_s2_adv & r_s1_valid & ~flush;

   // ---------------------------------------------------------------------
   // Stage 1 decode / extend
   // ---------------------------------------------------------------------
   always_comb begin
      w_imm   = '0;
      w_is_br = 1'b0;
      case (EXTOp)
         OP_I: w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         OP_S: w_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         OP_B: begin
            w_imm   = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            w_is_br = 1'b1;
         end
         // Bit 31 heads the replication so the U form works for both widths.
         OP_U: w_imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
         OP_J: begin
            w_imm   = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            w_is_br = 1'b1;
         end
         OP_SHAMT: begin
            if (XLEN == 64) begin
               w_imm = {{(XLEN-6){1'b0}}, instr[25:20]};
            end else begin
               w_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
            end
         end
         default: w_imm = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_imm   <= '0;
         r_s1_pc    <= '0;
         r_s1_br    <= 1'b0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
         end
         if (w_accept) begin
            r_s1_imm <= w_imm;
            r_s1_pc  <= pc;
            r_s1_br  <= w_is_br;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 target adder and output registers
   // ---------------------------------------------------------------------
   generate
      if (ADDR_REL != 0) begin : g_rel
         assign w_target = r_s1_br ? (r_s1_pc + r_s1_imm) : '0;
      end else begin : g_norel
         assign w_target = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s2_valid   <= 1'b0;
         r_out_imm    <= '0;
         r_out_target <= '0;
      end else begin
         if (flush) begin
            r_s2_valid <= 1'b0;
         end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s2_load) begin
            r_out_imm    <= r_s1_imm;
            r_out_target <= w_target;
         end
      end
   end

   assign out_valid  = r_s2_valid;
   assign out_imm    = r_out_imm;
   assign out_target = r_out_target;

   // ---------------------------------------------------------------------
   // Illegal EXTOp detection (optional)
   // ---------------------------------------------------------------------
`ifdef IMMGEN_ILLEGAL_DETECT_EN
   logic w_illegal;
   logic r_s1_ill;
   logic r_out_err;

   always_comb begin
      w_illegal = 1'b1;
      case (EXTOp)
         OP_S, OP_I, OP_SHAMT, OP_B, OP_U, OP_J: w_illegal = 1'b0;
         default:                                w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_ill  <= 1'b0;
         r_out_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_s1_ill <= w_illegal;
         end
         if (w_s2_load) begin
            r_out_err <= r_s1_ill;
         end
      end
   end

   assign out_err = r_out_err;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// tb_imm_gen_pipe
// ----------------------------------------------------------------------------
// Scoreboard bench for imm_gen_pipe. Two instances: XLEN=32 and XLEN=64.
// Stimulus pushes hand-computed expectations into per-instance queues; monitor
// processes pop and compare on each output handshake (sampled at negedge).
// ============================================================================
module tb_imm_gen_pipe;

   localparam logic [5:0] OP_S     = 6'b000001;
   localparam logic [5:0] OP_I     = 6'b000010;
   localparam logic [5:0] OP_SHAMT = 6'b000011;
   localparam logic [5:0] OP_B     = 6'b000100;
   localparam logic [5:0] OP_U     = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000110;

`ifdef IMMGEN_ILLEGAL_DETECT_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [63:0] imm;
      logic [63:0] tgt;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] instr;
   logic [5:0]  extop;
   logic        flush;
   logic        out_ready;

   logic        in_valid32, in_ready32, out_valid32, out_err32;
   logic [31:0] pc32, out_imm32, out_target32;
   logic        in_valid64, in_ready64, out_valid64, out_err64;
   logic [63:0] pc64, out_imm64, out_target64;

   exp_t q32[$];
   exp_t q64[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_push32 = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .ADDR_REL(1)) u_dut32 (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid32),
      .in_ready   (in_ready32),
      .instr      (instr),
      .EXTOp      (extop),
      .pc         (pc32),
      .flush      (flush),
      .out_valid  (out_valid32),
      .out_ready  (out_ready),
      .out_imm    (out_imm32),
      .out_target (out_target32),
      .out_err    (out_err32)
   );

   imm_gen_pipe #(.XLEN(64), .ADDR_REL(1)) u_dut64 (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid64),
      .in_ready   (in_ready64),
      .instr      (instr),
      .EXTOp      (extop),
      .pc         (pc64),
      .flush      (flush),
      .out_valid  (out_valid64),
      .out_ready  (out_ready),
      .out_imm    (out_imm64),
      .out_target (out_target64),
      .out_err    (out_err64)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Presents one vector starting at posedge+1; returns at posedge+1 after accept.
   task automatic send(input bit is64, input logic [5:0] op, input logic [31:0] ins,
                       input logic [63:0] p, input logic [63:0] ei, input logic [63:0] et,
                       input logic ee);
      exp_t e;
      bit   done = 1'b0;
      e.imm = ei;
      e.tgt = et;
      e.err = ee;
      extop = op;
      instr = ins;
      if (is64) begin
         pc64 = p;
         in_valid64 = 1'b1;
      end else begin
         pc32 = p[31:0];
         in_valid32 = 1'b1;
      end
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if ((is64 ? in_ready64 : in_ready32) && !flush) begin
            if (is64) q64.push_back(e);
            else begin
               q32.push_back(e);
               n_push32++;
            end
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_checks++;
         $display("FAIL send_timeout: in_ready never high (op %b)", op);
      end
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitors
   // ---------------------------------------------------------------------
   exp_t        m32_e, m64_e;
   bit          held = 1'b0;
   logic [31:0] h_imm, h_tgt;
   logic        h_err;

   always @(negedge clk) begin
      if (!rstn) begin
         held = 1'b0;
      end else if (out_valid32) begin
         if (held) begin
            check("hold_imm32", {32'h0, out_imm32}, {32'h0, h_imm});
            check("hold_tgt32", {32'h0, out_target32}, {32'h0, h_tgt});
            check("hold_err32", {63'h0, out_err32}, {63'h0, h_err});
         end
         if (out_ready) begin
            held = 1'b0;
            if (q32.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_out32: imm %h with empty scoreboard", out_imm32);
            end else begin
               m32_e = q32.pop_front();
               check("imm32", {32'h0, out_imm32}, {32'h0, m32_e.imm[31:0]});
               check("tgt32", {32'h0, out_target32}, {32'h0, m32_e.tgt[31:0]});
               check("err32", {63'h0, out_err32}, {63'h0, m32_e.err});
            end
         end else begin
            held  = 1'b1;
            h_imm = out_imm32;
            h_tgt = out_target32;
            h_err = out_err32;
         end
      end else begin
         held = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rstn && out_valid64 && out_ready) begin
         if (q64.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out64: imm %h with empty scoreboard", out_imm64);
         end else begin
            m64_e = q64.pop_front();
            check("imm64", out_imm64, m64_e.imm);
            check("tgt64", out_target64, m64_e.tgt);
            check("err64", {63'h0, out_err64}, {63'h0, m64_e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   int base;

   initial begin
      rstn = 1'b0;
      instr = '0;
      extop = '0;
      flush = 1'b0;
      out_ready = 1'b1;
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
      pc32 = '0;
      pc64 = '0;

      // Reset state
      #2;
      check("rst_in_ready", {63'h0, in_ready32}, 64'h0);
      check("rst_out_valid", {63'h0, out_valid32}, 64'h0);
      check("rst_out_imm", {32'h0, out_imm32}, 64'h0);
      check("rst_out_target", {32'h0, out_target32}, 64'h0);
      check("rst_out_err", {63'h0, out_err32}, 64'h0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      check("rel_in_ready32", {63'h0, in_ready32}, 64'h1);
      check("rel_in_ready64", {63'h0, in_ready64}, 64'h1);

      // Latency: I type
      send(0, OP_I, 32'hFFF00093, 64'h1000, 64'hFFFFFFFF, 64'h0, 1'b0);
      @(negedge clk);
      check("lat_early", {63'h0, out_valid32}, 64'h0);
      @(negedge clk);
      check("lat_2cyc", {63'h0, out_valid32}, 64'h1);
      @(posedge clk);
      #1;

      // Back-to-back directed vectors (XLEN=32)
      send(0, OP_I, 32'h7FF00093, 64'h0, 64'h000007FF, 64'h0, 1'b0);
      send(0, OP_I, 32'h80000093, 64'h0, 64'hFFFFF800, 64'h0, 1'b0);
      send(0, OP_S, 32'hFE000E23, 64'h0, 64'hFFFFFFFC, 64'h0, 1'b0);
      send(0, OP_S, 32'h00000FA3, 64'h0, 64'h0000001F, 64'h0, 1'b0);
      send(0, OP_B, 32'hFE000EE3, 64'h100, 64'hFFFFFFFC, 64'h000000FC, 1'b0);
      send(0, OP_B, 32'h00000863, 64'h200, 64'h00000010, 64'h00000210, 1'b0);
      send(0, OP_J, 32'h0080006F, 64'hFFFFFFFC, 64'h00000008, 64'h00000004, 1'b0);
      send(0, OP_J, 32'hFFFFF06F, 64'h2000, 64'hFFFFFFFE, 64'h00001FFE, 1'b0);
      send(0, OP_U, 32'h800002B7, 64'h0, 64'h80000000, 64'h0, 1'b0);
      send(0, OP_SHAMT, 32'h03F00013, 64'h0, 64'h0000001F, 64'h0, 1'b0);
      send(0, 6'b111111, 32'hFFFFFFFF, 64'h40, 64'h0, 64'h0, ERR_EN);
      send(0, 6'b000000, 32'h12345678, 64'h40, 64'h0, 64'h0, ERR_EN);
      send(0, 6'b000111, 32'h0080006F, 64'h40, 64'h0, 64'h0, ERR_EN);
      repeat (4) @(posedge clk);
      #1;
      check("drain32_a", q32.size(), 64'h0);

      // Backpressure: out_ready low for 3 cycles during a 4-entry stream
      out_ready = 1'b0;
      base = n_push32;
      fork
         begin
            send(0, OP_U, 32'h12345037, 64'h0, 64'h12345000, 64'h0, 1'b0);
            send(0, OP_U, 32'h00001037, 64'h0, 64'h00001000, 64'h0, 1'b0);
            send(0, OP_S, 32'h00000FA3, 64'h0, 64'h0000001F, 64'h0, 1'b0);
            send(0, OP_J, 32'h0080006F, 64'h10, 64'h00000008, 64'h00000018, 1'b0);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            check("bp_accept_cnt", n_push32 - base, 64'd2);
            check("bp_in_ready", {63'h0, in_ready32}, 64'h0);
            out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("drain32_bp", q32.size(), 64'h0);

      // Flush with two entries in flight and a concurrent input
      out_ready = 1'b0;
      send(0, OP_I, 32'h00100093, 64'h0, 64'h1, 64'h0, 1'b0);
      send(0, OP_I, 32'h00200093, 64'h0, 64'h2, 64'h0, 1'b0);
      flush = 1'b1;
      in_valid32 = 1'b1;
      extop = OP_I;
      instr = 32'h00300093;
      @(negedge clk);
      check("flush_pre_valid", {63'h0, out_valid32}, 64'h1);
      check("flush_no_accept", {63'h0, in_ready32}, 64'h0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid32 = 1'b0;
      q32.delete();
      check("flush_clear", {63'h0, out_valid32}, 64'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_none_emerge", {63'h0, out_valid32}, 64'h0);
      end
      @(posedge clk);
      #1;

      // Asynchronous reset mid-stream
      fork
         begin
            send(0, OP_I, 32'h00400093, 64'h0, 64'h4, 64'h0, 1'b0);
            send(0, OP_I, 32'h00500093, 64'h0, 64'h5, 64'h0, 1'b0);
            send(0, OP_I, 32'h00600093, 64'h0, 64'h6, 64'h0, 1'b0);
            send(0, OP_I, 32'h00700093, 64'h0, 64'h7, 64'h0, 1'b0);
         end
         begin
            repeat (2) @(posedge clk);
            #3 rstn = 1'b0;
            #1;
            check("arst_out_valid", {63'h0, out_valid32}, 64'h0);
            check("arst_out_imm", {32'h0, out_imm32}, 64'h0);
            check("arst_in_ready", {63'h0, in_ready32}, 64'h0);
            q32.delete();
            repeat (2) @(posedge clk);
            #1 rstn = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("drain32_rst", q32.size(), 64'h0);

      // XLEN=64 vectors
      send(1, OP_SHAMT, 32'h03F00013, 64'h0, 64'h000000000000003F, 64'h0, 1'b0);
      send(1, OP_U, 32'h800002B7, 64'h0, 64'hFFFFFFFF80000000, 64'h0, 1'b0);
      send(1, OP_I, 32'hFFF00093, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0);
      send(1, OP_B, 32'hFE000EE3, 64'h100, 64'hFFFFFFFFFFFFFFFC, 64'h00000000000000FC, 1'b0);
      send(1, OP_J, 32'h0080006F, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'h4, 1'b0);
      send(1, 6'b111111, 32'hFFFFFFFF, 64'h0, 64'h0, 64'h0, ERR_EN);
      repeat (4) @(posedge clk);
      #1;
      check("drain64", q64.size(), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
